// File: rtl/logic8_issue_ctrl.sv
// Issue controller for the 8-bit logic unit: request in, operands out, result + flags back.
// Optional LOGIC8_CHECK_EN adds chk_err, a sticky cross-check of lu_func against a local recompute.
module logic8_issue_ctrl #(
   parameter int WIDTH      = 8,
   parameter int LU_LATENCY = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_acc,
   output logic [WIDTH-1:0] lu_op_A,
   output logic [WIDTH-1:0] lu_op_B,
   output logic [1:0]       lu_op_mux,
   input  logic [WIDTH-1:0] lu_func,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   output logic             rsp_neg,
   output logic [WIDTH-1:0] acc
`ifdef LOGIC8_CHECK_EN
   ,
   output logic             chk_err
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [2:0] LAT_INIT = 3'(LU_LATENCY);

   state_t     state_reg;
   state_t     state_next;
   logic [2:0] cnt_reg;
   logic       accept;
   logic       capture;

   assign accept  = (state_reg == IDLE) && req_valid;
   assign capture = (state_reg == EXEC) && (cnt_reg == 3'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req_valid)         state_next = EXEC;
         EXEC:    if (cnt_reg == 3'd0)   state_next = RESP;
         RESP:    if (rsp_ready)         state_next = IDLE;
         default:                        state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state_reg)
         IDLE:    req_ready = 1'b1;
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Operands stay registered after the response so the unit input never glitches in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lu_op_A   <= '0;
         lu_op_B   <= '0;
         lu_op_mux <= 2'd0;
         cnt_reg   <= 3'd0;
         rsp_data  <= '0;
         rsp_zero  <= 1'b0;
         rsp_neg   <= 1'b0;
         acc       <= '0;
      end else begin
         if (accept) begin
            lu_op_A   <= req_acc ? acc : req_a;
            lu_op_B   <= req_b;
            lu_op_mux <= req_op;
            cnt_reg   <= LAT_INIT;
         end else if ((state_reg == EXEC) && (cnt_reg != 3'd0)) begin
            cnt_reg <= cnt_reg - 3'd1;
         end
         if (capture) begin
            rsp_data <= lu_func;
            rsp_zero <= (lu_func == '0);
            rsp_neg  <= lu_func[WIDTH-1];
            acc      <= lu_func;
         end
      end
   end

`ifdef LOGIC8_CHECK_EN
   logic [WIDTH-1:0] chk_expect;

   always_comb begin
      chk_expect = '0;
      case (lu_op_mux)
         2'd0:    chk_expect = lu_op_A | lu_op_B;
         2'd1:    chk_expect = lu_op_A & lu_op_B;
         2'd2:    chk_expect = lu_op_A ^ lu_op_B;
         default: chk_expect = ~lu_op_A + WIDTH'(1);
      endcase
   end

   // Sticky until reset so a single bad capture is never lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_err <= 1'b0;
      end else if (capture && (chk_expect != lu_func)) begin
         chk_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_logic8_issue_ctrl.sv
// Bench for logic8_issue_ctrl: latency-0 and latency-3 instances, transaction-level model,
// per-cycle comparison plus literal expectations from the test plan.
module tb_logic8_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   always #5 clk = ~clk;

   logic       req_valid [2];
   logic       req_ready [2];
   logic [1:0] req_op    [2];
   logic [7:0] req_a     [2];
   logic [7:0] req_b     [2];
   logic       req_acc   [2];
   logic [7:0] lu_op_A   [2];
   logic [7:0] lu_op_B   [2];
   logic [1:0] lu_op_mux [2];
   logic [7:0] lu_func   [2];
   logic       rsp_valid [2];
   logic       rsp_ready [2];
   logic [7:0] rsp_data  [2];
   logic       rsp_zero  [2];
   logic       rsp_neg   [2];
   logic [7:0] acc_o     [2];
   logic [7:0] fault     [2];
`ifdef LOGIC8_CHECK_EN
   logic       chk_err   [2];
`endif

   int n_checks = 0;
   int n_errors = 0;

   function automatic int lat_of(input int i);
      return (i == 0) ? 0 : 3;
   endfunction

   function automatic logic [7:0] lu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      case (op)
         2'd0:    r = a | b;
         2'd1:    r = a & b;
         2'd2:    r = a ^ b;
         default: r = ~a + 8'd1;
      endcase
      return r;
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic8_issue_ctrl #(.WIDTH(8), .LU_LATENCY(gi == 0 ? 0 : 3)) dut (
         .clk(clk), .rst(rst),
         .req_valid(req_valid[gi]), .req_ready(req_ready[gi]), .req_op(req_op[gi]),
         .req_a(req_a[gi]), .req_b(req_b[gi]), .req_acc(req_acc[gi]),
         .lu_op_A(lu_op_A[gi]), .lu_op_B(lu_op_B[gi]), .lu_op_mux(lu_op_mux[gi]),
         .lu_func(lu_func[gi]),
         .rsp_valid(rsp_valid[gi]), .rsp_ready(rsp_ready[gi]), .rsp_data(rsp_data[gi]),
         .rsp_zero(rsp_zero[gi]), .rsp_neg(rsp_neg[gi]), .acc(acc_o[gi])
`ifdef LOGIC8_CHECK_EN
         ,
         .chk_err(chk_err[gi])
`endif
      );
   end

   // Logic units: instance 0 combinational, instance 1 a 3-stage registered pipeline.
   logic [7:0] pipe [3];
   always @(posedge clk) begin
      pipe[0] <= lu_f(lu_op_mux[1], lu_op_A[1], lu_op_B[1]);
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
   end
   always_comb begin
      lu_func[0] = lu_f(lu_op_mux[0], lu_op_A[0], lu_op_B[0]) ^ fault[0];
      lu_func[1] = pipe[2] ^ fault[1];
   end

   // Transaction-level model: busy flag and cycles since accept decide the handshake signals.
   logic       m_busy [2];
   int         m_age  [2];
   logic [7:0] m_acc  [2];
   logic [7:0] m_a    [2];
   logic [7:0] m_b    [2];
   logic [1:0] m_mux  [2];
   logic [7:0] m_data [2];
   logic       m_zero [2];
   logic       m_neg  [2];
   logic       m_chk  [2];

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_busy[i] <= 1'b0; m_age[i] <= 0;     m_acc[i] <= 8'h00;
            m_a[i]    <= 8'h00; m_b[i]  <= 8'h00; m_mux[i] <= 2'd0;
            m_data[i] <= 8'h00; m_zero[i] <= 1'b0; m_neg[i] <= 1'b0; m_chk[i] <= 1'b0;
         end else if (!m_busy[i]) begin
            if (req_valid[i]) begin
               m_busy[i] <= 1'b1;
               m_age[i]  <= 0;
               m_a[i]    <= req_acc[i] ? m_acc[i] : req_a[i];
               m_b[i]    <= req_b[i];
               m_mux[i]  <= req_op[i];
            end
         end else if (m_age[i] <= lat_of(i)) begin
            m_age[i] <= m_age[i] + 1;
            if (m_age[i] == lat_of(i)) begin
               m_data[i] <= lu_f(m_mux[i], m_a[i], m_b[i]) ^ fault[i];
               m_acc[i]  <= lu_f(m_mux[i], m_a[i], m_b[i]) ^ fault[i];
               m_zero[i] <= (lu_f(m_mux[i], m_a[i], m_b[i]) ^ fault[i]) == 8'h00;
               m_neg[i]  <= (lu_f(m_mux[i], m_a[i], m_b[i]) ^ fault[i]) >= 8'h80;
               if (fault[i] != 8'h00) m_chk[i] <= 1'b1;
            end
         end else if (rsp_ready[i]) begin
            m_busy[i] <= 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, i, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         chk("req_ready", i, 8'(req_ready[i]), 8'(!m_busy[i]));
         chk("rsp_valid", i, 8'(rsp_valid[i]), 8'(m_busy[i] && (m_age[i] == lat_of(i) + 1)));
         chk("lu_op_A", i, lu_op_A[i], m_a[i]);
         chk("lu_op_B", i, lu_op_B[i], m_b[i]);
         chk("lu_op_mux", i, 8'(lu_op_mux[i]), 8'(m_mux[i]));
         chk("acc", i, acc_o[i], m_acc[i]);
         chk("rsp_data", i, rsp_data[i], m_data[i]);
         chk("rsp_zero", i, 8'(rsp_zero[i]), 8'(m_zero[i]));
         chk("rsp_neg", i, 8'(rsp_neg[i]), 8'(m_neg[i]));
`ifdef LOGIC8_CHECK_EN
         chk("chk_err", i, 8'(chk_err[i]), 8'(m_chk[i]));
`endif
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
   endtask

   // One full transaction; junk req_* is presented while busy to show it is ignored.
   task automatic do_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic accf, input int stall, input logic early,
                         output logic [7:0] data, output int lat);
      int n;
      req_valid[i] = 1'b1; req_op[i] = op; req_a[i] = a; req_b[i] = b; req_acc[i] = accf;
      n = 0;
      while (!req_ready[i] && n < 20) begin tick(); n++; end
      if (n >= 20) chk("req_timeout", i, 8'd1, 8'd0);
      tick();
      req_op[i] = 2'd2; req_a[i] = 8'h5A; req_b[i] = 8'hA5; req_acc[i] = 1'b0;
      rsp_ready[i] = early;
      lat = 0;
      while (!rsp_valid[i] && lat < 20) begin tick(); lat++; end
      if (lat >= 20) chk("rsp_timeout", i, 8'd1, 8'd0);
      data = rsp_data[i];
      rsp_ready[i] = 1'b0;
      req_valid[i] = 1'b0;
      for (int k = 0; k < stall; k++) tick();
      rsp_ready[i] = 1'b1;
      tick();
      rsp_ready[i] = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      int         lat;
      int         seen;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; req_op[i] = 2'd0; req_a[i] = 8'h00; req_b[i] = 8'h00;
         req_acc[i] = 1'b0; rsp_ready[i] = 1'b0; fault[i] = 8'h00;
      end
      rst = 1'b1;
      tick(); tick();
      chk("reset_rsp_valid", 0, 8'(rsp_valid[0]), 8'd0);
      chk("reset_acc", 1, acc_o[1], 8'h00);
      rst = 1'b0;
      tick();
      chk("idle_req_ready", 0, 8'(req_ready[0]), 8'd1);

      do_req(0, 2'd0, 8'h0F, 8'hF0, 1'b0, 0, 1'b0, d, lat);
      chk("ior_data", 0, d, 8'hFF);
      chk("ior_latency", 0, 8'(lat), 8'd1);
      chk("ior_zero", 0, 8'(rsp_zero[0]), 8'd0);
      chk("ior_neg", 0, 8'(rsp_neg[0]), 8'd1);
      chk("ior_acc", 0, acc_o[0], 8'hFF);

      do_req(0, 2'd1, 8'hAA, 8'h55, 1'b0, 0, 1'b0, d, lat);
      chk("and_data", 0, d, 8'h00);
      chk("and_zero", 0, 8'(rsp_zero[0]), 8'd1);
      do_req(0, 2'd3, 8'h77, 8'h12, 1'b1, 0, 1'b0, d, lat);
      chk("comp_acc_opA", 0, lu_op_A[0], 8'h00);
      chk("comp_acc_data", 0, d, 8'h00);

      do_req(0, 2'd2, 8'h3C, 8'h0F, 1'b0, 0, 1'b1, d, lat);
      chk("xor_data", 0, d, 8'h33);
      do_req(0, 2'd3, 8'h00, 8'h00, 1'b1, 0, 1'b0, d, lat);
      chk("neg_acc_data", 0, d, 8'hCD);
      chk("neg_acc_neg", 0, 8'(rsp_neg[0]), 8'd1);

      do_req(0, 2'd3, 8'h01, 8'h99, 1'b0, 5, 1'b0, d, lat);
      chk("stall_data", 0, d, 8'hFF);
      chk("stall_data_after", 0, rsp_data[0], 8'hFF);

      do_req(1, 2'd1, 8'hF3, 8'h3F, 1'b0, 1, 1'b1, d, lat);
      chk("lat3_data", 1, d, 8'h33);
      chk("lat3_latency", 1, 8'(lat), 8'd4);
      do_req(1, 2'd0, 8'h00, 8'h40, 1'b1, 0, 1'b0, d, lat);
      chk("lat3_acc_data", 1, d, 8'h73);

      // Abort an in-flight request on instance 1 with an asynchronous reset.
      req_valid[1] = 1'b1; req_op[1] = 2'd0; req_a[1] = 8'h81; req_b[1] = 8'h18; req_acc[1] = 1'b0;
      tick();
      req_valid[1] = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_acc", 1, acc_o[1], 8'h00);
      chk("abort_opA", 1, lu_op_A[1], 8'h00);
      chk("abort_data", 1, rsp_data[1], 8'h00);
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (rsp_valid[1]) seen++;
      end
      chk("abort_no_rsp", 1, 8'(seen), 8'd0);

      fault[0] = 8'h04;
      do_req(0, 2'd0, 8'h11, 8'h22, 1'b0, 0, 1'b0, d, lat);
      chk("fault_data", 0, d, 8'h37);
      fault[0] = 8'h00;
`ifdef LOGIC8_CHECK_EN
      chk("chk_err_set", 0, 8'(chk_err[0]), 8'd1);
`endif
      do_req(0, 2'd2, 8'h00, 8'h0F, 1'b1, 0, 1'b0, d, lat);
      chk("post_fault_data", 0, d, 8'h38);
`ifdef LOGIC8_CHECK_EN
      chk("chk_err_sticky", 0, 8'(chk_err[0]), 8'd1);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
`ifdef LOGIC8_CHECK_EN
      chk("chk_err_clear", 0, 8'(chk_err[0]), 8'd0);
`endif
      chk("final_acc", 0, acc_o[0], 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/logic8_issue_ctrl.md
Name: logic8_issue_ctrl

Overview:
- Initiator side of the 8-bit logic-unit interface.
- Accepts logic-op requests over a valid/ready channel and drives op_A, op_B and op_mux into the logic unit.
- Waits the unit's configured latency, captures Func, updates an internal accumulator, and returns the result with flags over a valid/ready response channel.
- Sits between the CPU control sequencer and the logic unit.

Parameters:
- WIDTH, 8: operand/result width; the logic unit is 8-bit, so other values are for reuse only.
- LU_LATENCY, 0: cycles from operands applied to Func valid; 0 = combinational unit, valid range 0..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset; one clock, clk.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_op  input  2  op select: 0 ior, 1 and, 2 xor, 3 comp (two's-complement negate of A).
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- req_acc  input  1  1 = use accumulator as A and ignore req_a.
- lu_op_A  output  WIDTH  to logic unit op_A.
- lu_op_B  output  WIDTH  to logic unit op_B.
- lu_op_mux  output  2  to logic unit op_mux.
- lu_func  input  WIDTH  from logic unit Func.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  WIDTH  captured result.
- rsp_zero  output  1  rsp_data == 0.
- rsp_neg  output  1  rsp_data[WIDTH-1].
- acc  output  WIDTH  accumulator; holds the last captured result.

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1 after reset deasserts; rsp_valid=0.
- Reset values of registered outputs: rsp_data, rsp_zero, rsp_neg, acc, lu_op_A, lu_op_B, lu_op_mux all 0; wait counter 0.
- Reset mid-operation aborts any in-flight request. No response is produced and acc is not updated.
- FSM IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid&&req_ready at an edge: register lu_op_A = (req_acc ? acc : req_a), lu_op_B = req_b, lu_op_mux = req_op.
  - Load counter = LU_LATENCY; go to EXEC.
- FSM EXEC:
  - req_ready=0; lu_op_* held stable.
  - If counter != 0: decrement.
  - If counter == 0: at this edge capture rsp_data = lu_func, rsp_zero, rsp_neg, acc = lu_func; go to RESP.
  - EXEC therefore lasts LU_LATENCY+1 cycles.
- FSM RESP:
  - rsp_valid=1; rsp_data, flags and lu_op_* are stable while rsp_valid && !rsp_ready.
  - On rsp_valid&&rsp_ready: go to IDLE; rsp_valid falls next cycle.
- Latency: rsp_valid rises LU_LATENCY+1 cycles after the request-accept edge.
- Throughput: at most one request per LU_LATENCY+3 cycles, because req_ready is low in EXEC and RESP.
- No bypass: req_ready is 0 in the cycle rsp is accepted. A new request is accepted one cycle later, in IDLE.
- Operand/accumulator rules:
  - req_acc=1 on the first request after reset uses acc=0.
  - comp ignores lu_op_B, but it is still registered from req_b.
- Arithmetic is computed by the logic unit only. The controller does no recomputation except under the optional feature.
- req_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
- lu_op_* retain their last values in IDLE.

Optional Feature:
- Macro: LOGIC8_CHECK_EN.
- When defined:
  - Adds output port chk_err (1 bit, reset 0).
  - At the capture edge, the controller computes the expected result internally from lu_op_A, lu_op_B and lu_op_mux (ior/and/xor/negate), compares it with lu_func, and sets chk_err sticky on mismatch.
  - chk_err clears only on rst.
- When undefined: the port, the checker logic and its state are absent. All other behaviour is identical.

Test Plan:
- LU_LATENCY=0, req op=0 A=8'h0F B=8'hF0, rsp_ready=1 -> rsp_valid one cycle after accept; rsp_data=8'hFF, zero=0, neg=1; acc=8'hFF.
- op=1 A=8'hAA B=8'h55 -> rsp_data=8'h00, rsp_zero=1; then op=3 with req_acc=1 -> lu_op_A=8'h00, rsp_data=8'h00.
- op=2 A=8'h3C B=8'h0F, then op=3 req_acc=1 -> first rsp_data=8'h33, second rsp_data=8'hCD, neg=1.
- rsp_ready held 0 for 5 cycles after op=3 A=8'h01 -> rsp_valid stays 1, rsp_data=8'hFF stable; req_ready=0 throughout; IDLE after rsp_ready=1.
- LU_LATENCY=3 with a 3-stage registered model unit, op=1 A=8'hF3 B=8'h3F -> rsp_valid exactly 4 cycles after accept; rsp_data=8'h33.
- rst pulsed during EXEC, then LOGIC8_CHECK_EN with a fault-injected unit -> all outputs 0 and no response after the reset; chk_err=1 after the faulty capture and stays 1 until rst.
